// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between the EX/MEM and MEM/WB registers.
// Ports: EX/MEM inputs (ex_*); a request/ack data-memory port (dm_*); upstream stall (mem_stall);
//        MEM/WB register outputs (wb_*); mem_err pulses alongside wb_valid when an access timed out.
// Latency: non-memory ops take 1 cycle; memory ops take k+1 cycles (ack in k-th dm_req cycle); stall holds EX/MEM meanwhile.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_alu_out,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [INSTR_W-1:0] ex_instruction,
  output logic               mem_stall,
  output logic               dm_req,
  output logic               dm_we,
  output logic [DATA_W-1:0]  dm_addr,
  output logic [DATA_W-1:0]  dm_wdata,
  input  logic [DATA_W-1:0]  dm_rdata,
  input  logic               dm_ack,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_alu_out,
  output logic [DATA_W-1:0]  wb_mem_data,
  output logic               wb_is_load,
  output logic [INSTR_W-1:0] wb_instruction,
  output logic               mem_err
);

  // A zero-width counter is illegal, so TIMEOUT=0 still gets one (unused) bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             timeout_hit;
  logic             done;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_stall   = 1'b0;
    done        = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // An ack arriving on the timeout cycle still counts as a normal completion.
        done      = dm_ack | timeout_hit;
        mem_stall = ~done;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      dm_req         <= 1'b0;
      dm_we          <= 1'b0;
      dm_addr        <= '0;
      dm_wdata       <= '0;
      wb_valid       <= 1'b0;
      wb_alu_out     <= '0;
      wb_mem_data    <= '0;
      wb_is_load     <= 1'b0;
      wb_instruction <= '0;
      mem_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_err <= 1'b0;
          if (mem_op) begin
            // Launch the access; MEM/WB gets a bubble while it is in flight.
            dm_req   <= 1'b1;
            dm_we    <= ex_mem_write;
            dm_addr  <= ex_alu_out;
            dm_wdata <= ex_store_data;
            cnt      <= '0;
            wb_valid <= 1'b0;
          end else begin
            dm_req         <= 1'b0;
            wb_valid       <= ex_valid;
            wb_alu_out     <= ex_alu_out;
            wb_instruction <= ex_instruction;
            wb_is_load     <= 1'b0;
            wb_mem_data    <= '0;
          end
        end
        ACCESS: begin
          if (done) begin
            // Upstream has been holding EX/MEM, so its fields still describe this access.
            dm_req         <= 1'b0;
            wb_valid       <= 1'b1;
            wb_alu_out     <= ex_alu_out;
            wb_instruction <= ex_instruction;
            wb_is_load     <= ex_mem_read & ~ex_mem_write;
            wb_mem_data    <= dm_ack ? dm_rdata : '0;
            mem_err        <= ~dm_ack;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
          end
        end
        default: begin
          dm_req   <= 1'b0;
          wb_valid <= 1'b0;
          mem_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
